// File: rtl/gpio_arb_pkg.sv
// Shared types and helpers for the GPIO bus arbiter.
//   arb_state_e : arbiter FSM state (idle / waiting for device response)
//   idx_width   : bits needed to index n hosts
package gpio_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i  : per-host request vector
//   prio_i : index of the host with highest priority this cycle
//   gnt_o  : one-hot grant (zero when nothing requests)
//   idx_o  : index of the granted host
//   any_o  : at least one request present
module rr_pick
  import gpio_arb_pkg::*;
#(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0]                req_i,
  input  logic [idx_width(NumReq)-1:0]     prio_i,
  output logic [NumReq-1:0]                gnt_o,
  output logic [idx_width(NumReq)-1:0]     idx_o,
  output logic                             any_o
);

  localparam int IW = idx_width(NumReq);

  // One extra bit so prio + offset never overflows before the wrap.
  logic [IW:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, prio_i} + (IW+1)'(i);
      if (cand >= (IW+1)'(NumReq)) cand = cand - (IW+1)'(NumReq);
      if (!any_o && req_i[cand[IW-1:0]]) begin
        gnt_o[cand[IW-1:0]] = 1'b1;
        idx_o               = cand[IW-1:0];
        any_o               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_bus_arb.sv
// Round-robin arbiter sharing one GPIO register slave between NumReq hosts.
// One outstanding transaction; a new grant may issue in the cycle the
// previous response returns, so back-to-back traffic runs one per cycle.
//
// Ports:
//   clk_i, rst_ni         : clock, async active-low reset
//   host_req_i/host_gnt_o : per-host request / same-cycle grant (one-hot)
//   host_addr_i, host_we_i, host_be_i, host_wdata_i : packed host fields
//   host_rvalid_o/err_o   : response strobes routed to the owning host
//   host_rdata_o          : read data broadcast, qualified by host_rvalid_o
//   dev_*                 : single device-side request/response port
//
// Optional build macro GPIO_ARB_TIMEOUT_EN: if the device is silent for
// TimeoutCycles after a grant, the owner receives an error response with
// zero data and the arbiter returns to idle.
module gpio_bus_arb
  import gpio_arb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0]                host_req_i,
  output logic [NumReq-1:0]                host_gnt_o,
  input  logic [NumReq*AddressWidth-1:0]   host_addr_i,
  input  logic [NumReq-1:0]                host_we_i,
  input  logic [NumReq*DataWidth/8-1:0]    host_be_i,
  input  logic [NumReq*DataWidth-1:0]      host_wdata_i,
  output logic [NumReq-1:0]                host_rvalid_o,
  output logic [DataWidth-1:0]             host_rdata_o,
  output logic [NumReq-1:0]                host_err_o,
  output logic                             dev_req_o,
  output logic [AddressWidth-1:0]          dev_addr_o,
  output logic                             dev_we_o,
  output logic [DataWidth/8-1:0]           dev_be_o,
  output logic [DataWidth-1:0]             dev_wdata_o,
  input  logic                             dev_rvalid_i,
  input  logic [DataWidth-1:0]             dev_rdata_i,
  input  logic                             dev_err_i
);

  localparam int IW = idx_width(NumReq);
  localparam int BW = DataWidth / 8;

  if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 1 || (DataWidth % 8) != 0) begin : g_bad_params
    $error("gpio_bus_arb: illegal parameter set");
  end

  // Per-host views of the flat host buses.
  logic [NumReq-1:0][AddressWidth-1:0] addr_a;
  logic [NumReq-1:0][BW-1:0]           be_a;
  logic [NumReq-1:0][DataWidth-1:0]    wdata_a;
  assign addr_a  = host_addr_i;
  assign be_a    = host_be_i;
  assign wdata_a = host_wdata_i;

  arb_state_e           state_q;
  logic [IW-1:0]        prio_q, owner_q;
  logic [NumReq-1:0]    pick_gnt, owner_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any, resp_v, free, grant, timeout;

  rr_pick #(.NumReq(NumReq)) u_pick (
    .req_i  (host_req_i),
    .prio_i (prio_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Device responses only count while a transaction is outstanding.
  assign resp_v = (state_q == ARB_WAIT) & dev_rvalid_i;
  // Nothing is granted while reset is held, keeping every output at zero.
  assign free   = rst_ni & ((state_q == ARB_IDLE) | resp_v);
  assign grant  = free & pick_any;

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles + 1);
  logic [CW-1:0] cnt_q;
  // cnt_q is 0 in the first WAIT cycle, so the pulse lands exactly
  // TimeoutCycles cycles after the grant. free is already low here
  // (no rvalid), so no grant can coincide with a timeout.
  assign timeout = (state_q == ARB_WAIT) & ~dev_rvalid_i &
                   (cnt_q == CW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  assign owner_oh = {{(NumReq-1){1'b0}}, 1'b1} << owner_q;

  assign host_gnt_o    = grant ? pick_gnt : '0;
  assign host_rvalid_o = (resp_v | timeout) ? owner_oh : '0;
  assign host_err_o    = ((resp_v & dev_err_i) | timeout) ? owner_oh : '0;
  assign host_rdata_o  = resp_v ? dev_rdata_i : '0;

  assign dev_req_o   = grant;
  assign dev_addr_o  = grant ? addr_a[pick_idx]    : '0;
  assign dev_we_o    = grant ? host_we_i[pick_idx] : 1'b0;
  assign dev_be_o    = grant ? be_a[pick_idx]      : '0;
  assign dev_wdata_o = grant ? wdata_a[pick_idx]   : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      prio_q  <= '0;
      owner_q <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else if (grant) begin
      owner_q <= pick_idx;
      prio_q  <= (pick_idx == IW'(NumReq - 1)) ? '0 : pick_idx + IW'(1);
      state_q <= ARB_WAIT;
`ifdef GPIO_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else if (resp_v | timeout) begin
      state_q <= ARB_IDLE;
    end
`ifdef GPIO_ARB_TIMEOUT_EN
    else if (state_q == ARB_WAIT) begin
      cnt_q <= cnt_q + CW'(1);
    end
`endif
  end

endmodule
